sbox_share_arbiter: RTL and testbench
=====================================

// Module: sbox_share_arbiter
// PURPOSE
//  Time-shares one 16-byte S-Box substitution array between two requesters.
//  - Round datapath: full 128-bit SubBytes.
//  - Key expansion: 32-bit SubWord.
//  Grants at most one request per cycle, drives the array and tracks each in-flight op's owner.
//  Steers results back to the owner after a fixed array latency.
//  Sits between the iterative AES round controller and the key-schedule engine.
// PARAMETERS
//  NB_BYTE       8   bits per byte; any other value is a bad configuration
//  N_BYTES       16  bytes per state
//  NB_WORD       32  key-word width (4 bytes)
//  SBOX_LATENCY  1   array latency in cycles; legal values 0 or 1
//  MAX_WAIT      4   max consecutive cycles the key requester may be blocked (>=1)
// PORTS
//  i_clock        in   1        clock
//  i_reset        in   1        synchronous, active-high reset
//  i_rnd_valid    in   1        round request valid
//  i_rnd_state    in   128      round state to substitute
//  o_rnd_ready    out  1        round request accepted this cycle
//  o_rnd_valid    out  1        round result valid (1-cycle pulse)
//  o_rnd_state    out  128      substituted round state
//  i_key_valid    in   1        key request valid
//  i_key_word     in   32       key word (already rotated)
//  o_key_ready    out  1        key request accepted this cycle
//  o_key_valid    out  1        key result valid (1-cycle pulse)
//  o_key_word     out  32       substituted key word
//  o_sbox_state   out  128      array input
//  o_sbox_valid   out  1        array input valid (clock enable)
//  i_sbox_state   in   128      array output
//  o_stat_rnd     out  16       round grant count (see CONFIGURATION)
//  o_stat_key     out  16       key grant count
//  o_stat_stall   out  16       key-blocked cycle count
// BEHAVIOUR
//  - Byte lane ii occupies bits [ii*8 +: 8].
//  - Transfer occurs on valid & ready. Ready is combinational from the valids and the wait counter.
//  - Grant rule (o_rnd_ready and o_key_ready are never both 1):
//    - Key is granted when key_valid & (!rnd_valid | wait_cnt==MAX_WAIT).
//    - Otherwise round is granted when rnd_valid.
//  - wait_cnt:
//    - +1 each cycle key_valid & !key granted, saturating at MAX_WAIT.
//    - Cleared on key grant or when !key_valid.
//  - Array input:
//    - Round grant: o_sbox_state = i_rnd_state.
//    - Key grant: {96'h0, i_key_word}.
//    - No grant: hold the previous value.
//    - o_sbox_valid = any grant.
//  - Tag pipe: {valid, owner} delayed by SBOX_LATENCY.
//    - At pipe output, raise o_rnd_valid or o_key_valid for one cycle with i_sbox_state (key: bits [31:0]).
//    - SBOX_LATENCY=0: result in the same cycle as the grant, combinational.
//  - Results have no backpressure; consumers must take them on the pulse.
//  - Throughput is one op per cycle; back-to-back grants to alternating owners are legal.
//  - Simultaneous requests with wait_cnt<MAX_WAIT: round wins and wait_cnt increments.
//  - Reset values:
//    - All o_*_valid = 0, data outputs = 0.
//    - wait_cnt = 0, tag pipe cleared, stats = 0.
//    - Ready outputs are forced 0 while i_reset=1.
//  - Reset mid-operation: in-flight ops are discarded; no result pulse appears after reset is sampled.
// CONFIGURATION
//  - Macro SBOX_ARB_STATS_EN:
//    - Defined: o_stat_* are 16-bit saturating counters of round grants, key grants and cycles with key_valid & !key_ready.
//    - Not defined: counters are not built and o_stat_* are tied to 16'h0.
//  - Arbitration is identical in both builds.
// STRUCTURE
//  - Package sbox_arb_pkg:
//    - Owner encoding OWNER_RND=1'b0, OWNER_KEY=1'b1.
//    - NB_STAT=16.
//    - Key-lane offset constant.
//  - Sub-module sbox_arb_tag_pipe: {valid, owner} delay line of depth SBOX_LATENCY with sync clear.
//  - The arbiter, wait counter and output steering stay in the top level.
// TESTING
//  1. Round only, i_rnd_state byte0=8'h53, rest 8'h00 -> o_rnd_state byte0=8'hED, rest 8'h63, o_rnd_valid one cycle after grant.
//  2. Key only, i_key_word=32'hCF4F3C09 -> o_key_word=32'h8A84EB01, o_key_valid after SBOX_LATENCY, o_rnd_valid stays 0.
//  3. Both valid continuously, MAX_WAIT=4 -> 4 round grants then 1 key grant, repeating; key is never blocked >4 cycles.
//  4. Alternating round/key grants on consecutive cycles -> results return in grant order with correct owners and no lost or duplicate pulses.
//  5. Assert i_reset for 1 cycle with an op in flight -> no o_*_valid pulse afterwards; all outputs 0; wait_cnt restarts at 0.
//  6. SBOX_ARB_STATS_EN defined, 10 round + 3 key grants -> o_stat_rnd=10, o_stat_key=3; without the macro all o_stat_*=0.

Source files
------------

// File: rtl/sbox_arb_pkg.sv
// Shared types and constants for the S-Box share arbiter.
package sbox_arb_pkg;

  // Owner tag carried alongside each in-flight array operation.
  typedef enum logic {
    OWNER_RND = 1'b0,
    OWNER_KEY = 1'b1
  } owner_e;

  localparam int unsigned NB_STAT = 16;

  // The key word occupies the low lanes of the array input.
  localparam int unsigned KEY_LANE_LSB = 0;

  // Saturating increment for the statistics counters.
  function automatic logic [NB_STAT-1:0] sat_inc(input logic [NB_STAT-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sbox_arb_tag_pipe.sv
// Delay line for the {valid, owner} tag of each array operation.
// Depth matches the array latency; depth 0 is a combinational bypass.
module sbox_arb_tag_pipe
  import sbox_arb_pkg::*;
#(
  parameter int unsigned Latency = 1
) (
  input  logic   clk_i,
  input  logic   clr_i,
  input  logic   valid_i,
  input  owner_e owner_i,
  output logic   valid_o,
  output owner_e owner_o
);

  if (Latency == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign owner_o = owner_i;
  end else begin : g_delay
    logic   [Latency-1:0] valid_q;
    owner_e               owner_q [Latency];

    // Shift the tag one stage per cycle; clear drops everything in flight.
    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        valid_q <= '0;
        for (int i = 0; i < int'(Latency); i++) begin
          owner_q[i] <= OWNER_RND;
        end
      end else begin
        valid_q[0] <= valid_i;
        owner_q[0] <= owner_i;
        for (int i = 1; i < int'(Latency); i++) begin
          valid_q[i] <= valid_q[i-1];
          owner_q[i] <= owner_q[i-1];
        end
      end
    end

    assign valid_o = valid_q[Latency-1];
    assign owner_o = owner_q[Latency-1];
  end

endmodule

// File: rtl/sbox_share_arbiter.sv
// Time-shares one 16-byte S-Box array between the round datapath (128-bit SubBytes)
// and the key schedule (32-bit SubWord). Key requests win once they have been blocked
// MAX_WAIT consecutive cycles; otherwise the round requester has priority.
// Optional macro SBOX_ARB_STATS_EN builds the grant/stall statistics counters.
module sbox_share_arbiter
  import sbox_arb_pkg::*;
#(
  parameter int unsigned NB_BYTE      = 8,
  parameter int unsigned N_BYTES      = 16,
  parameter int unsigned NB_WORD      = 32,
  parameter int unsigned SBOX_LATENCY = 1,
  parameter int unsigned MAX_WAIT     = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_rnd_valid,
  input  logic [N_BYTES*NB_BYTE-1:0] i_rnd_state,
  output logic                       o_rnd_ready,
  output logic                       o_rnd_valid,
  output logic [N_BYTES*NB_BYTE-1:0] o_rnd_state,
  input  logic                       i_key_valid,
  input  logic [NB_WORD-1:0]         i_key_word,
  output logic                       o_key_ready,
  output logic                       o_key_valid,
  output logic [NB_WORD-1:0]         o_key_word,
  output logic [N_BYTES*NB_BYTE-1:0] o_sbox_state,
  output logic                       o_sbox_valid,
  input  logic [N_BYTES*NB_BYTE-1:0] i_sbox_state,
  output logic [NB_STAT-1:0]         o_stat_rnd,
  output logic [NB_STAT-1:0]         o_stat_key,
  output logic [NB_STAT-1:0]         o_stat_stall
);

  localparam int unsigned NbState = N_BYTES * NB_BYTE;
  localparam int unsigned WaitW   = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] MaxWaitC = WaitW'(MAX_WAIT);

  // Reject configurations the datapath cannot support at elaboration time.
  if (NB_BYTE != 8) begin : g_bad_nb_byte
    $error("sbox_share_arbiter: NB_BYTE must be 8");
  end
  if (NB_WORD != 4 * NB_BYTE) begin : g_bad_nb_word
    $error("sbox_share_arbiter: NB_WORD must be 4 bytes");
  end
  if (SBOX_LATENCY > 1) begin : g_bad_latency
    $error("sbox_share_arbiter: SBOX_LATENCY must be 0 or 1");
  end
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("sbox_share_arbiter: MAX_WAIT must be at least 1");
  end

  logic [WaitW-1:0]   wait_q, wait_d;
  logic [NbState-1:0] sbox_hold_q, sbox_hold_d;
  logic [NbState-1:0] key_lane;
  logic               rnd_gnt, key_gnt;
  logic               tag_valid;
  owner_e             tag_owner;
  logic               rnd_pulse, key_pulse;

  // Arbitration, wait counter next-state and array input steering.
  always_comb begin
    key_gnt  = !i_reset && i_key_valid && (!i_rnd_valid || (wait_q == MaxWaitC));
    rnd_gnt  = !i_reset && i_rnd_valid && !key_gnt;

    key_lane = '0;
    key_lane[KEY_LANE_LSB +: NB_WORD] = i_key_word;

    if (rnd_gnt) begin
      o_sbox_state = i_rnd_state;
    end else if (key_gnt) begin
      o_sbox_state = key_lane;
    end else begin
      o_sbox_state = sbox_hold_q;
    end
    o_sbox_valid = rnd_gnt || key_gnt;
    sbox_hold_d  = o_sbox_state;

    if (!i_key_valid || key_gnt) begin
      wait_d = '0;
    end else if (wait_q != MaxWaitC) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  assign o_rnd_ready = rnd_gnt;
  assign o_key_ready = key_gnt;

  // Wait counter and held array input; reset clears both.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wait_q      <= '0;
      sbox_hold_q <= '0;
    end else begin
      wait_q      <= wait_d;
      sbox_hold_q <= sbox_hold_d;
    end
  end

  sbox_arb_tag_pipe #(
    .Latency (SBOX_LATENCY)
  ) u_tag_pipe (
    .clk_i   (i_clock),
    .clr_i   (i_reset),
    .valid_i (o_sbox_valid),
    .owner_i (key_gnt ? OWNER_KEY : OWNER_RND),
    .valid_o (tag_valid),
    .owner_o (tag_owner)
  );

  // Steer array output back to the owner; reset masks any pulse still in the pipe.
  always_comb begin
    rnd_pulse   = tag_valid && (tag_owner == OWNER_RND) && !i_reset;
    key_pulse   = tag_valid && (tag_owner == OWNER_KEY) && !i_reset;
    o_rnd_valid = rnd_pulse;
    o_key_valid = key_pulse;
    o_rnd_state = rnd_pulse ? i_sbox_state : '0;
    o_key_word  = key_pulse ? i_sbox_state[KEY_LANE_LSB +: NB_WORD] : '0;
  end

`ifdef SBOX_ARB_STATS_EN
  logic [NB_STAT-1:0] stat_rnd_q, stat_rnd_d;
  logic [NB_STAT-1:0] stat_key_q, stat_key_d;
  logic [NB_STAT-1:0] stat_stall_q, stat_stall_d;

  // Saturating grant and key-stall counters.
  always_comb begin
    stat_rnd_d   = rnd_gnt ? sat_inc(stat_rnd_q) : stat_rnd_q;
    stat_key_d   = key_gnt ? sat_inc(stat_key_q) : stat_key_q;
    stat_stall_d = (i_key_valid && !key_gnt) ? sat_inc(stat_stall_q) : stat_stall_q;
  end

  // Statistics registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stat_rnd_q   <= '0;
      stat_key_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_rnd_q   <= stat_rnd_d;
      stat_key_q   <= stat_key_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign o_stat_rnd   = stat_rnd_q;
  assign o_stat_key   = stat_key_q;
  assign o_stat_stall = stat_stall_q;
`else
  assign o_stat_rnd   = '0;
  assign o_stat_key   = '0;
  assign o_stat_stall = '0;
`endif

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Directed bench for sbox_share_arbiter with an AES S-Box array model of latency 1.
// Statistics expectations follow SBOX_ARB_STATS_EN.
module tb_sbox_share_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         rnd_valid_i, rnd_ready, rnd_valid_o;
  logic [127:0] rnd_state_i, rnd_state_o;
  logic         key_valid_i, key_ready, key_valid_o;
  logic [31:0]  key_word_i, key_word_o;
  logic [127:0] sbox_state_o;
  logic         sbox_valid_o;
  logic [127:0] arr_q = '0;
  logic [15:0]  stat_rnd, stat_key, stat_stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sbox_tbl [256];

  always #5 clk = ~clk;

  sbox_share_arbiter #(
    .NB_BYTE      (8),
    .N_BYTES      (16),
    .NB_WORD      (32),
    .SBOX_LATENCY (1),
    .MAX_WAIT     (4)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rnd_valid  (rnd_valid_i),
    .i_rnd_state  (rnd_state_i),
    .o_rnd_ready  (rnd_ready),
    .o_rnd_valid  (rnd_valid_o),
    .o_rnd_state  (rnd_state_o),
    .i_key_valid  (key_valid_i),
    .i_key_word   (key_word_i),
    .o_key_ready  (key_ready),
    .o_key_valid  (key_valid_o),
    .o_key_word   (key_word_o),
    .o_sbox_state (sbox_state_o),
    .o_sbox_valid (sbox_valid_o),
    .i_sbox_state (arr_q),
    .o_stat_rnd   (stat_rnd),
    .o_stat_key   (stat_key),
    .o_stat_stall (stat_stall)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (x != 8'h00 && gf_mul(x, 8'(c)) == 8'h01) inv = 8'(c);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox_calc(8'(i));
  end

  // Array model: registered substitution, enabled by o_sbox_valid.
  always @(posedge clk) begin
    if (sbox_valid_o) begin
      for (int i = 0; i < 16; i++) arr_q[i*8 +: 8] <= sbox_tbl[sbox_state_o[i*8 +: 8]];
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] Sub53 = 128'h636363636363636363636363636363ED;

  logic         own4 [4];
  logic [127:0] rdat4 [4];
  logic [127:0] rexp4 [4];
  logic [31:0]  kdat4 [4];
  logic [31:0]  kexp4 [4];

  initial begin
    own4  = '{1'b0, 1'b1, 1'b0, 1'b1};
    rdat4 = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0, 128'h53, 128'h0};
    rexp4 = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h0, Sub53, 128'h0};
    kdat4 = '{32'h0, 32'h10111213, 32'h0, 32'hCF4F3C09};
    kexp4 = '{32'h0, 32'hca82c97d, 32'h0, 32'h8A84EB01};

    rst = 1'b1;
    rnd_valid_i = 1'b0;
    key_valid_i = 1'b0;
    rnd_state_i = '0;
    key_word_i  = '0;
    tick();
    tick();
    // Readies forced low while reset is high.
    rnd_valid_i = 1'b1;
    key_valid_i = 1'b1;
    @(negedge clk);
    check_eq("rst_rnd_ready", rnd_ready, 1'b0);
    check_eq("rst_key_ready", key_ready, 1'b0);
    check_eq("rst_sbox_valid", sbox_valid_o, 1'b0);
    tick();
    rst = 1'b0;
    rnd_valid_i = 1'b0;
    key_valid_i = 1'b0;
    @(negedge clk);
    check_eq("rst_rnd_valid", rnd_valid_o, 1'b0);
    check_eq("rst_key_valid", key_valid_o, 1'b0);
    check_eq("rst_rnd_state", rnd_state_o, 128'h0);
    check_eq("rst_key_word", key_word_o, 32'h0);
    check_eq("rst_sbox_state", sbox_state_o, 128'h0);
    check_eq("rst_stats", {stat_rnd, stat_key, stat_stall}, 48'h0);

    // Round only.
    tick();
    rnd_valid_i = 1'b1;
    rnd_state_i = 128'h53;
    @(negedge clk);
    check_eq("t1_rnd_ready", rnd_ready, 1'b1);
    check_eq("t1_key_ready", key_ready, 1'b0);
    check_eq("t1_sbox_in", sbox_state_o, 128'h53);
    tick();
    rnd_valid_i = 1'b0;
    @(negedge clk);
    check_eq("t1_rnd_pulse", rnd_valid_o, 1'b1);
    check_eq("t1_rnd_state", rnd_state_o, Sub53);
    check_eq("t1_key_quiet", key_valid_o, 1'b0);
    tick();
    @(negedge clk);
    check_eq("t1_pulse_end", rnd_valid_o, 1'b0);
    check_eq("t1_sbox_hold", sbox_state_o, 128'h53);
    check_eq("t1_sbox_idle", sbox_valid_o, 1'b0);

    // Key only.
    tick();
    key_valid_i = 1'b1;
    key_word_i  = 32'hCF4F3C09;
    @(negedge clk);
    check_eq("t2_key_ready", key_ready, 1'b1);
    check_eq("t2_sbox_in", sbox_state_o, 128'hCF4F3C09);
    tick();
    key_valid_i = 1'b0;
    @(negedge clk);
    check_eq("t2_key_pulse", key_valid_o, 1'b1);
    check_eq("t2_key_word", key_word_o, 32'h8A84EB01);
    check_eq("t2_rnd_quiet", rnd_valid_o, 1'b0);

    // Both valid continuously: 4 round grants then 1 key grant.
    tick();
    rnd_valid_i = 1'b1;
    key_valid_i = 1'b1;
    rnd_state_i = '0;
    key_word_i  = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("t3_key_rdy%0d", i), key_ready, (i % 5) == 4);
      check_eq($sformatf("t3_rnd_rdy%0d", i), rnd_ready, (i % 5) != 4);
      if (i > 0) begin
        check_eq($sformatf("t3_key_res%0d", i), key_valid_o, ((i - 1) % 5) == 4);
        check_eq($sformatf("t3_rnd_res%0d", i), rnd_valid_o, ((i - 1) % 5) != 4);
      end
      tick();
    end
    rnd_valid_i = 1'b0;
    key_valid_i = 1'b0;

    // Alternating owners on consecutive cycles.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        rnd_valid_i = !own4[k];
        key_valid_i = own4[k];
        rnd_state_i = rdat4[k];
        key_word_i  = kdat4[k];
      end else begin
        rnd_valid_i = 1'b0;
        key_valid_i = 1'b0;
      end
      @(negedge clk);
      if (k < 4) begin
        check_eq($sformatf("t4_rdy%0d", k), {rnd_ready, key_ready}, {!own4[k], own4[k]});
      end
      if (k > 0) begin
        check_eq($sformatf("t4_vld%0d", k - 1), {rnd_valid_o, key_valid_o},
                 {!own4[k-1], own4[k-1]});
        check_eq($sformatf("t4_rdat%0d", k - 1), rnd_state_o, rexp4[k-1]);
        check_eq($sformatf("t4_kdat%0d", k - 1), key_word_o, kexp4[k-1]);
      end
      tick();
    end

    // Reset with an op in flight and the wait counter non-zero.
    rnd_valid_i = 1'b1;
    key_valid_i = 1'b1;
    rnd_state_i = 128'h53;
    key_word_i  = 32'hCF4F3C09;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_pulse", {rnd_valid_o, key_valid_o}, 2'b00);
    check_eq("t5_rst_ready", {rnd_ready, key_ready}, 2'b00);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_eq("t5_no_pulse", {rnd_valid_o, key_valid_o}, 2'b00);
        check_eq("t5_data_zero", {rnd_state_o, key_word_o}, 160'h0);
        check_eq("t5_stats_zero", {stat_rnd, stat_key, stat_stall}, 48'h0);
      end
      check_eq($sformatf("t5_key_rdy%0d", i), key_ready, i == 4);
      tick();
    end
    rnd_valid_i = 1'b0;
    key_valid_i = 1'b0;
    @(negedge clk);
`ifdef SBOX_ARB_STATS_EN
    check_eq("t5_stat_stall", stat_stall, 16'd4);
`else
    check_eq("t5_stat_stall", stat_stall, 16'd0);
`endif

    // Statistics: 10 round grants then 3 key grants from a clean reset.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rnd_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rnd_valid_i = 1'b0;
    key_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    key_valid_i = 1'b0;
    @(negedge clk);
`ifdef SBOX_ARB_STATS_EN
    check_eq("t6_stat_rnd", stat_rnd, 16'd10);
    check_eq("t6_stat_key", stat_key, 16'd3);
    check_eq("t6_stat_stall", stat_stall, 16'd0);
`else
    check_eq("t6_stat_rnd", stat_rnd, 16'd0);
    check_eq("t6_stat_key", stat_key, 16'd0);
    check_eq("t6_stat_stall", stat_stall, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
